// File: rtl/mem_pkg.sv
// Shared definitions for the single-port scratch memory family.
// Contents:
//   state_t      - clear-sequencer FSM encoding (ST_CLEAR, ST_IDLE)
//   calc_addr_w  - address width for a given depth (minimum 1 bit)
//   calc_be_w    - byte-enable width for a given data width
package mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    function automatic int calc_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int calc_be_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_sp_param_if.sv
// Request/response bundle between a register-file style master and
// mem_sp_param.
//   en, r_w, addr, d_in, be : request, driven by the master
//   d_out, rd_valid         : registered read response
//   busy                    : clear sweep running, requests are dropped
//   dbg_state               : clear-sequencer state, for observation only
// Handshake: a request is taken on any posedge where en=1 and busy=0;
// there is no ready/stall beyond busy. A read answers with rd_valid=1 for
// exactly the cycle after it was taken.
interface mem_sp_param_if
    import mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32
);
    localparam int ADDR_W = calc_addr_w(DEPTH);
    localparam int BE_W   = calc_be_w(DATA_W);

    logic              en;
    logic              r_w;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d_in;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] d_out;
    logic              rd_valid;
    logic              busy;
    state_t            dbg_state;

    modport master (
        output en, r_w, addr, d_in, be,
        input  d_out, rd_valid, busy, dbg_state
    );

    modport slave (
        input  en, r_w, addr, d_in, be,
        output d_out, rd_valid, busy, dbg_state
    );
endinterface

// File: rtl/mem_sp_param_clr_seq.sv
// mem_clr_seq: post-reset clear sweep. Walks clr_addr from 0 to DEPTH-1,
// one location per cycle, then parks in ST_IDLE until the next reset.
//   clk, rst  : clock, synchronous active-high reset
//   busy      : high while the sweep owns the array
//   clr_we    : write strobe for the zero word at clr_addr
//   clr_addr  : location being cleared this cycle
//   state     : current FSM state
module mem_clr_seq
    import mem_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output state_t            state
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end
            end
            ST_IDLE: ;
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign busy     = (state_q == ST_CLEAR);
    assign clr_addr = clr_cnt_q;
    assign state    = state_q;
endmodule

// File: rtl/mem_sp_param.sv
// mem_sp_param: parametrised single-port synchronous RAM with per-byte
// write enables, a one-cycle read-valid strobe and a hardware clear sweep
// after every reset.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_sp_param_if slave port (request in, response out)
module mem_sp_param
    import mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_sp_param_if.slave    bus
);
    localparam int ADDR_W = calc_addr_w(DEPTH);
    localparam int BE_W   = calc_be_w(DATA_W);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    state_t            seq_state;

    mem_clr_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .state    (seq_state)
    );

    // Only reachable when DEPTH is not a power of two.
    logic in_range;
    assign in_range = ({1'b0, bus.addr} < (ADDR_W + 1)'(DEPTH));

    logic acc_wr, acc_rd;
    assign acc_wr = !busy && bus.en &&  bus.r_w;
    assign acc_rd = !busy && bus.en && !bus.r_w;

    logic [DATA_W-1:0] cur_word;
    assign cur_word = in_range ? mem[bus.addr] : '0;

    // Byte merge: disabled lanes rewrite their current contents.
    logic [BE_W-1:0][7:0] wr_merge;
    for (genvar g = 0; g < BE_W; g++) begin : g_be
        assign wr_merge[g] = bus.be[g] ? bus.d_in[g*8 +: 8] : cur_word[g*8 +: 8];
    end

    // Array port: the sweep owns it while busy, the master otherwise.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.addr;
        mem_wdata = wr_merge;
        if (!rst) begin
            if (busy) begin
                mem_we    = clr_we;
                mem_waddr = clr_addr;
                mem_wdata = '0;
            end else begin
                mem_we = acc_wr && in_range;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    logic [DATA_W-1:0] d_out_q, d_out_d;
    logic              rd_valid_q, rd_valid_d;

    always_comb begin
        d_out_d    = d_out_q;
        rd_valid_d = 1'b0;
        if (acc_rd) begin
            d_out_d    = cur_word;
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_out_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            d_out_q    <= d_out_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.d_out     = d_out_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.busy      = busy;
    assign bus.dbg_state = seq_state;
endmodule

// File: doc/mem_sp_param.md
# mem_sp_param

Parametrised single-port, half-duplex synchronous RAM; successor to the fixed 16x32 memory. Adds configurable width and depth, an explicit enable, per-byte write enables, a read-valid strobe, and a hardware clear sequencer. The sequencer zeroes every location after reset, not just the addressed one. Sits between a register-file style master and local storage wherever the team needs small scratch memories.

## Interface
- DATA_W, 16, data width in bits; must be a multiple of 8.
- DEPTH, 32, number of words; any value ≥ 2, power of two not required.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- BE_W, DATA_W/8, byte-enable width; derived.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  request valid; ignored while busy=1.
- r_w  in  1  1 = write, 0 = read.
- addr  in  ADDR_W  word address.
- d_in  in  DATA_W  write data.
- be  in  BE_W  byte write enables; be[i] gates d_in[8i+7:8i].
- d_out  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle pulse; d_out is valid this cycle.
- busy  out  1  clear sweep in progress; requests dropped.

## Operation
- Two-state FSM: CLEAR and IDLE.
- Posedge with rst=1:
  - state←CLEAR, clr_cnt←0.
  - d_out←0, rd_valid←0, busy←1.
  - No memory write.
- CLEAR with rst=0, each posedge:
  - mem[clr_cnt]←0, clr_cnt←clr_cnt+1.
  - When clr_cnt==DEPTH-1, that location is written, state←IDLE and busy←0.
- IDLE, en=1, r_w=1: for each i with be[i]=1, mem[addr] byte i←d_in byte i; other bytes keep their value. rd_valid←0.
- IDLE, en=1, r_w=0: d_out←mem[addr], rd_valid←1.
- IDLE, en=0: no access; rd_valid←0; d_out holds its last value.
- Out-of-range address (addr ≥ DEPTH, possible only when DEPTH is not a power of two):
  - Write is dropped.
  - Read returns d_out←0 with rd_valid←1.
- Writes with be=0 are legal no-ops.
- While busy=1, en is ignored entirely: no write, no read, rd_valid stays 0.
- rst asserted mid-sweep or mid-access: the reset action wins on that edge, and the sweep restarts from location 0.
- Contents are undefined before the first completed sweep. Simulation must not depend on an initial block.

## Timing
- Read latency: 1 cycle. Request sampled at edge N; d_out and rd_valid are valid after edge N, and rd_valid drops after edge N+1 unless another read is issued.
- Back-to-back reads: rd_valid stays high; d_out updates every cycle.
- Write-then-read of the same address on consecutive cycles returns the new data.
- Clear duration: busy is high from the first reset edge through exactly DEPTH posedges after rst deasserts. It is first low after posedge DEPTH following release.
- Only one access per cycle (single port); there is no same-cycle read/write conflict.

## Structure
- Shared package mem_pkg holds:
  - the FSM state encoding (ST_CLEAR, ST_IDLE);
  - a localparam function for ADDR_W/BE_W derivation, reused by future memory variants.
- Sub-module mem_clr_seq: FSM plus clr_cnt. Outputs busy, clr_we and clr_addr. Top level muxes clr_addr and zero data onto the array port while busy.
- Array inferred as reg [DATA_W-1:0] mem [0:DEPTH-1]. The byte-enable write is a generate loop over BE_W.

## Test plan
- Reset then sweep, DATA_W=16, DEPTH=32: rst high 2 cycles, then low → busy=1 for exactly 32 posedges after release; reads of all 32 addresses then return 0x0000.
- Byte-enable write: write 0xABCD with be=2'b11 to addr 5, then 0x1234 with be=2'b01 → read addr 5 gives 0xAB34, rd_valid high one cycle later.
- Requests during busy: issue write 0xFFFF to addr 0 at sweep cycle 3 → ignored, rd_valid stays 0; after sweep, addr 0 reads 0x0000.
- Reset mid-sweep: assert rst at sweep cycle 10 for 1 cycle → clr_cnt restarts at 0 and busy lasts a further DEPTH cycles.
- Non-power-of-two, DEPTH=24, DATA_W=32: write 0xDEADBEEF to addr 23 and to addr 27 → addr 23 reads 0xDEADBEEF; addr 27 reads 0x00000000 with rd_valid=1.
- Back-to-back reads of addr 1,2,3 with distinct stored values → d_out tracks them on consecutive cycles, and rd_valid stays continuously high for 3 cycles.
